// File: rtl/regwrite_trace_pkg.sv
// Shared types and constants for the register-write trace transmitter.
package regwrite_trace_pkg;

  localparam logic REC_WRITE = 1'b0;
  localparam logic REC_DUMP  = 1'b1;

  localparam int NUM_REGS  = 32;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  // Widest cycle stamp a record can carry; narrower stamps are zero-extended.
  localparam int CYC_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 kind;
    logic [CYC_W_MAX-1:0] cycle;
    logic [REG_W-1:0]     reg_idx;
    logic [DATA_W-1:0]    data;
  } rec_t;

endpackage

// File: rtl/regwrite_trace_tx_fifo.sv
// Single-clock first-word-fall-through FIFO; push while full is accepted only
// when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regwrite_trace_tx.sv
// Register-write trace transmitter: timestamps regfile writes, queues them and
// streams records; on request dumps all registers. TRACE_DROP_COUNT_EN adds drop_count.
module regwrite_trace_tx
  import regwrite_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [REG_W-1:0]  ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic              dump_req,
  input  logic [DATA_W-1:0] data_readRegA,
  output logic [REG_W-1:0]  ctrl_readRegA,
  output logic              dump_active,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic              rec_kind,
  output logic [CYC_W-1:0]  rec_cycle,
  output logic [REG_W-1:0]  rec_reg,
  output logic [DATA_W-1:0] rec_data,
  output logic              lost,
  output logic              dump_done,
  output logic [15:0]       drop_count
);

  // Only write events are queued, so the kind bit is not stored.
  localparam int FIFO_W = CYC_W + REG_W + DATA_W;

  state_t            state_reg, state_next;
  logic [REG_W-1:0]  idx_reg, idx_next;
  logic [CYC_W-1:0]  cycle_reg;
  logic [CYC_W-1:0]  dump_stamp_reg;
  logic              lost_reg;

  logic              capture, drop, valid;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;
  rec_t              rec;

  assign fifo_din = {cycle_reg, ctrl_writeReg, data_writeReg};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    capture       = ctrl_writeEnable && (ctrl_writeReg != '0);
    rec           = '0;
    valid         = 1'b0;
    dump_active   = 1'b0;
    ctrl_readRegA = '0;
    dump_done     = 1'b0;
    state_next    = state_reg;
    idx_next      = idx_reg;
    fifo_pop      = 1'b0;
    fifo_push     = 1'b0;
    drop          = 1'b0;

    case (state_reg)
      IDLE, DRAIN: begin
        valid = !fifo_empty;
        if (valid) begin
          rec.kind    = REC_WRITE;
          rec.cycle   = CYC_W_MAX'(fifo_dout[FIFO_W-1 -: CYC_W]);
          rec.reg_idx = fifo_dout[DATA_W +: REG_W];
          rec.data    = fifo_dout[DATA_W-1:0];
        end
        fifo_pop = valid && rec_ready;
        if (state_reg == IDLE) begin
          if (dump_req) state_next = DRAIN;
        end else if (fifo_empty) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        valid         = 1'b1;
        dump_active   = 1'b1;
        ctrl_readRegA = idx_reg;
        rec.kind      = REC_DUMP;
        rec.cycle     = CYC_W_MAX'(dump_stamp_reg);
        rec.reg_idx   = idx_reg;
        rec.data      = data_readRegA;
        if (rec_ready) begin
          if (idx_reg == REG_W'(NUM_REGS - 1)) state_next = DONE;
          else                                 idx_next   = idx_reg + REG_W'(1);
        end
      end
      DONE: begin
        dump_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Captures are only accepted in IDLE; anything else is a dropped event.
    fifo_push = capture && (state_reg == IDLE) && (!fifo_full || fifo_pop);
    drop      = capture && !fifo_push;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cycle_reg      <= '0;
      dump_stamp_reg <= '0;
      lost_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cycle_reg <= cycle_reg + CYC_W'(1);
      if (state_reg == IDLE && dump_req) dump_stamp_reg <= cycle_reg;
      if (drop) lost_reg <= 1'b1;
    end
  end

  assign rec_valid = valid;
  assign rec_kind  = rec.kind;
  assign rec_cycle = rec.cycle[CYC_W-1:0];
  assign rec_reg   = rec.reg_idx;
  assign rec_data  = rec.data;
  assign lost      = lost_reg;

  generate
    if (CYC_W < CYC_W_MAX) begin : g_cyc_pad
      logic unused_cycle_hi;
      assign unused_cycle_hi = ^rec.cycle[CYC_W_MAX-1:CYC_W];
    end
  endgenerate

`ifdef TRACE_DROP_COUNT_EN
  logic [15:0] drop_count_reg;

  always_ff @(posedge clock) begin
    if (reset)                                   drop_count_reg <= '0;
    else if (drop && drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_regwrite_trace_tx.sv
// Self-checking bench for regwrite_trace_tx: queue-based reference model plus
// scenario tasks for capture, overflow, dump, mixed traffic and reset mid-dump.
module tb_regwrite_trace_tx;
  import regwrite_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CYC_W = 16;
`ifdef TRACE_DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_DRAIN = 1, M_SCAN = 2, M_DONE = 3;

  typedef struct packed {
    logic             kind;
    logic [CYC_W-1:0] cyc;
    logic [4:0]       r;
    logic [31:0]      d;
  } trec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic        dump_req = 1'b0;
  logic [31:0] data_readRegA;
  logic [4:0]  ctrl_readRegA;
  logic        dump_active;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic        rec_kind;
  logic [CYC_W-1:0] rec_cycle;
  logic [4:0]  rec_reg;
  logic [31:0] rec_data;
  logic        lost;
  logic        dump_done;
  logic [15:0] drop_count;

  logic [31:0] regs [32];
  trec_t       obs;
  int          tests_run = 0;
  int          tests_failed = 0;

  assign data_readRegA = regs[ctrl_readRegA];
  assign obs = {rec_kind, rec_cycle, rec_reg, rec_data};

  regwrite_trace_tx #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .dump_req(dump_req),
    .data_readRegA(data_readRegA), .ctrl_readRegA(ctrl_readRegA),
    .dump_active(dump_active), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_cycle(rec_cycle), .rec_reg(rec_reg),
    .rec_data(rec_data), .lost(lost), .dump_done(dump_done),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Reference model: expected record stream as a queue plus the dump phase.
  trec_t       m_q[$];
  int          m_mode = M_IDLE;
  logic [4:0]  m_idx = '0;
  logic [CYC_W-1:0] m_cyc = '0;
  logic [CYC_W-1:0] m_stamp = '0;
  logic        m_lost = 1'b0;
  logic [15:0] m_drops = '0;
  logic        exp_valid = 1'b0;
  logic        exp_active = 1'b0;
  logic        exp_done = 1'b0;
  trec_t       exp_rec = '0;

  initial begin : model
    bit    hs, cap;
    int    pre;
    trec_t tmp;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_q.delete();
        m_mode = M_IDLE; m_idx = '0; m_lost = 1'b0; m_drops = '0; m_cyc = '0;
      end else begin
        hs  = exp_valid && rec_ready;
        pre = m_q.size();
        cap = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        if ((m_mode == M_IDLE || m_mode == M_DRAIN) && hs) tmp = m_q.pop_front();
        if (cap && m_mode == M_IDLE && (pre < DEPTH || hs)) begin
          tmp = {REC_WRITE, m_cyc, ctrl_writeReg, data_writeReg};
          m_q.push_back(tmp);
        end else if (cap) begin
          m_lost = 1'b1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        case (m_mode)
          M_IDLE:  if (dump_req) begin m_mode = M_DRAIN; m_stamp = m_cyc; end
          M_DRAIN: if (pre == 0) begin m_mode = M_SCAN; m_idx = '0; end
          M_SCAN:  if (hs) begin
                     if (m_idx == 5'd31) m_mode = M_DONE;
                     else m_idx = m_idx + 5'd1;
                   end
          default: m_mode = M_IDLE;
        endcase
        m_cyc = m_cyc + 1'b1;
      end
      if (m_mode == M_SCAN) begin
        exp_valid = 1'b1;
        exp_rec   = {REC_DUMP, m_stamp, m_idx, regs[m_idx]};
      end else if (m_mode != M_DONE && m_q.size() > 0) begin
        exp_valid = 1'b1;
        exp_rec   = m_q[0];
      end else begin
        exp_valid = 1'b0;
        exp_rec   = '0;
      end
      exp_active = (m_mode == M_SCAN);
      exp_done   = (m_mode == M_DONE);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({rec_valid, obs, lost, dump_done, dump_active, ctrl_readRegA, drop_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%0b rec=%h lost=%0b done=%0b active=%0b idx=%0d drops=%0d, required all 0",
               rec_valid, obs, lost, dump_done, dump_active, ctrl_readRegA, drop_count);
    end
  endtask

  task automatic test_write();
    trec_t want;
    for (int i = 0; i < 40 && m_cyc != 16'd10; i++) tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'd123; rec_ready = 1'b1;
    tick();
    ctrl_writeEnable = 1'b0;
    @(negedge clock);
    want = {REC_WRITE, 16'd10, 5'd5, 32'd123};
    tests_run++;
    if (rec_valid !== 1'b1 || obs !== want) begin
      tests_failed++;
      $display("FAIL write_r5: got valid=%0b rec=%h, required valid=1 rec=%h", rec_valid, obs, want);
    end
    tests_run++;
    if (lost !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_r5_lost: got %0b required 0", lost);
    end
  endtask

  task automatic test_r0();
    tick();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'd7;
    tick();
    ctrl_writeEnable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests_run++;
      if (rec_valid !== 1'b0 || lost !== 1'b0) begin
        tests_failed++;
        $display("FAIL r0_ignored: got valid=%0b lost=%0b, required valid=0 lost=0", rec_valid, lost);
      end
      tick();
    end
  endtask

  task automatic test_full();
    trec_t q[$];
    trec_t t;
    logic [15:0] want_drops;
    rec_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'($urandom_range(1, 31));
      data_writeReg    = $urandom;
      t = {REC_WRITE, m_cyc, ctrl_writeReg, data_writeReg};
      if (i < 16) q.push_back(t);
    end
    tick();
    ctrl_writeEnable = 1'b0;
    rec_ready = 1'b1;
    @(negedge clock);
    want_drops = DC_EN ? 16'd1 : 16'd0;
    tests_run++;
    if (lost !== 1'b1 || drop_count !== want_drops) begin
      tests_failed++;
      $display("FAIL full_drop: got lost=%0b drops=%0d, required lost=1 drops=%0d", lost, drop_count, want_drops);
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rec_valid !== 1'b1 || obs !== q[i]) begin
        tests_failed++;
        $display("FAIL full_order[%0d]: got valid=%0b rec=%h, required valid=1 rec=%h", i, rec_valid, obs, q[i]);
      end
      tick();
      @(negedge clock);
    end
    tests_run++;
    if (rec_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_empty_after: got valid=%0b required 0", rec_valid);
    end
  endtask

  task automatic test_dump();
    trec_t want;
    int n, dones, done_at;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 80 && m_cyc != 16'd50; i++) tick();
    dump_req = 1'b1; rec_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (rec_valid && n < 40) begin
        want = {REC_DUMP, 16'd50, 5'(n), 32'(n * 3)};
        tests_run++;
        if (obs !== want) begin
          tests_failed++;
          $display("FAIL dump_rec[%0d]: got %h required %h", n, obs, want);
        end
        n++;
      end
      if (dump_done) begin dones++; done_at = n; end
      tick();
    end
    @(negedge clock);
    tests_run++;
    if (n !== 32 || dones !== 1 || done_at !== 32 || dump_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_summary: got records=%0d done_pulses=%0d done_after=%0d active=%0b, required 32 1 32 0",
               n, dones, done_at, dump_active);
    end
  endtask

  task automatic test_back_to_back();
    trec_t q[$];
    trec_t t, want;
    logic [CYC_W-1:0] stamp;
    int k;
    bit seen_scan, wrote, finished;
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'($urandom_range(1, 31));
      data_writeReg    = $urandom;
      t = {REC_WRITE, m_cyc, ctrl_writeReg, data_writeReg};
      q.push_back(t);
    end
    tick();
    ctrl_writeEnable = 1'b0; dump_req = 1'b1; stamp = m_cyc;
    tick();
    dump_req = 1'b0;
    k = 0; seen_scan = 0; wrote = 0; finished = 0;
    for (int i = 0; i < 300 && !finished; i++) begin
      rec_ready = ~rec_ready;
      if (seen_scan && !wrote) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'($urandom_range(1, 31));
        data_writeReg    = $urandom;
        wrote = 1;
      end else begin
        ctrl_writeEnable = 1'b0;
      end
      @(negedge clock);
      tests_run++;
      if (rec_valid !== exp_valid || (exp_valid && obs !== exp_rec) || lost !== m_lost ||
          dump_active !== exp_active || dump_done !== exp_done) begin
        tests_failed++;
        $display("FAIL b2b_cycle: got v=%0b rec=%h lost=%0b act=%0b done=%0b, required v=%0b rec=%h lost=%0b act=%0b done=%0b",
                 rec_valid, obs, lost, dump_active, dump_done, exp_valid, exp_rec, m_lost, exp_active, exp_done);
      end
      if (rec_valid && rec_ready) begin
        if (k < 3) want = q[k];
        else       want = {REC_DUMP, stamp, 5'(k - 3), 32'((k - 3) * 3)};
        tests_run++;
        if (obs !== want) begin
          tests_failed++;
          $display("FAIL b2b_order[%0d]: got %h required %h", k, obs, want);
        end
        k++;
      end
      if (dump_active) seen_scan = 1;
      if (dump_done) finished = 1;
      tick();
    end
    ctrl_writeEnable = 1'b0;
    rec_ready = 1'b1;
    tests_run++;
    if (!finished || k !== 35 || lost !== 1'b1 || drop_count !== (DC_EN ? 16'd1 : 16'd0)) begin
      tests_failed++;
      $display("FAIL b2b_summary: got finished=%0b records=%0d lost=%0b drops=%0d, required 1 35 1 %0d",
               finished, k, lost, drop_count, DC_EN ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_scan();
    trec_t want;
    logic [CYC_W-1:0] stamp;
    logic [31:0] d;
    bit found, done_seen;
    rec_ready = 1'b1;
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clock);
      if (dump_active && ctrl_readRegA == 5'd12) found = 1;
      else tick();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL mid_scan_reach: got no SCAN at idx 12 within bound, required reached");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({rec_valid, obs, lost, dump_done, dump_active, ctrl_readRegA, drop_count} !== '0) begin
      tests_failed++;
      $display("FAIL mid_scan_reset: got valid=%0b rec=%h lost=%0b done=%0b active=%0b, required all 0",
               rec_valid, obs, lost, dump_done, dump_active);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clock);
      if (dump_done || dump_active) done_seen = 1;
    end
    tests_run++;
    if (done_seen) begin
      tests_failed++;
      $display("FAIL mid_scan_no_done: got dump_done/dump_active after reset, required none");
    end
    tick();
    d = $urandom;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = d; stamp = m_cyc;
    tick();
    ctrl_writeEnable = 1'b0;
    @(negedge clock);
    want = {REC_WRITE, stamp, 5'd7, d};
    tests_run++;
    if (rec_valid !== 1'b1 || obs !== want) begin
      tests_failed++;
      $display("FAIL post_reset_write: got valid=%0b rec=%h, required valid=1 rec=%h", rec_valid, obs, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    test_reset();
    test_write();
    test_r0();
    test_full();
    test_dump();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regwrite_trace_tx.md
Name: regwrite_trace_tx

Overview:
- Hardware transmitter for processor register-write traces.
- Snoops the regfile write port every cycle. Timestamps each non-r0 write with a free-running cycle count, buffers it in a FIFO, and streams it out as a record over a valid/ready interface.
- On request, takes over regfile read port A and streams out all 32 register values as dump records.
- Sits beside processor and regfile; feeds a debug UART or host bridge. It is the producing end of the write-log / register-dump stream.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CYC_W, 16, cycle-stamp width; counter wraps modulo 2^CYC_W.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ctrl_writeEnable  in  1  regfile write enable (snooped)
- ctrl_writeReg  in  5  regfile write index (snooped)
- data_writeReg  in  32  regfile write data (snooped)
- dump_req  in  1  single-cycle request to dump all registers
- data_readRegA  in  32  regfile port A data; combinational w.r.t. ctrl_readRegA
- ctrl_readRegA  out  5  port A index override
- dump_active  out  1  high while the block owns port A; wrapper muxes ctrl_readRegA in
- rec_valid  out  1  record valid
- rec_ready  in  1  consumer ready
- rec_kind  out  1  0 = write event, 1 = dump entry
- rec_cycle  out  CYC_W  cycle stamp (write event) or dump-start stamp (dump entry)
- rec_reg  out  5  register index
- rec_data  out  32  register data
- lost  out  1  sticky: a write event was dropped
- dump_done  out  1  one-cycle pulse after the last dump record is accepted
- drop_count  out  16  dropped-event count (optional feature)

Behaviour:
- Reset: every output 0; state IDLE; FIFO empty; cycle counter 0.
- Cycle counter increments every cycle after reset and wraps.
- A record transfers on a cycle where rec_valid && rec_ready. rec_* fields are held stable while rec_valid && !rec_ready.
- Capture rule: an event is pushed when ctrl_writeEnable && ctrl_writeReg != 0 and state is IDLE. The record is {kind 0, counter value that cycle, reg, data}.
  - The pushed entry becomes visible on rec_* the next cycle at the earliest (1-cycle latency).
- FIFO full: push and pop in the same cycle is allowed, nothing is lost. A push when full with no pop drops the event and sets lost.
- FIFO empty: rec_valid = 0 in IDLE.
- FSM states and transitions:
  - IDLE: FIFO head drives rec_*. dump_req moves to DRAIN; the counter value that cycle is latched as dump_stamp.
  - DRAIN: captures disabled. FIFO contents keep streaming out. When the FIFO is empty, go to SCAN with idx = 0.
  - SCAN: dump_active = 1; ctrl_readRegA = idx; rec_valid = 1.
    - Record is {kind 1, dump_stamp, idx, data_readRegA}.
    - On handshake, idx increments. Handshake at idx = 31 goes to DONE.
  - DONE: dump_done = 1 for one cycle; dump_active = 0; return to IDLE.
- Any write event arriving in DRAIN, SCAN or DONE is dropped and sets lost.
- dump_req outside IDLE is ignored.
- r0 writes are never captured and never count as dropped.
- lost is cleared only by reset.
- Reset mid-dump: returns to IDLE immediately. dump_active falls in the cycle after reset is sampled. FIFO is flushed and no dump_done is issued.

Optional Feature:
- Macro: TRACE_DROP_COUNT_EN.
- Defined: drop_count increments, saturating at 16'hFFFF, on every event that sets lost.
- Undefined: drop_count is tied to 0 and no counter logic is built.

Decomposition:
- Package regwrite_trace_pkg holds:
  - REC_WRITE = 1'b0, REC_DUMP = 1'b1
  - state encoding typedef (IDLE, DRAIN, SCAN, DONE)
  - NUM_REGS = 32
  - record struct {kind, cycle, reg, data}
- Sub-module trace_fifo: synchronous single-clock FIFO with full/empty, parameterised by depth and data width.

Test Plan:
- Write r5 = 123 at cycle 10 with rec_ready = 1 -> one record {0, 10, 5, 123} valid at cycle 11; lost stays 0.
- Write r0 = 7 -> no record is produced.
- rec_ready = 0, 17 consecutive non-r0 writes with DEPTH = 16 -> 16 records retained in order; lost = 1; drop_count = 1 with the macro, 0 without.
- Regfile preloaded rN = N*3, dump_req at cycle 50, FIFO empty -> 32 records {1, 50, N, 3N} for N = 0..31 in order; dump_done pulses once after N = 31; dump_active is 0 afterwards.
- 3 queued events, then dump_req, rec_ready toggling every other cycle -> the 3 events come out first, then 32 dump records. A write issued during SCAN is not recorded and sets lost.
- Reset asserted mid-SCAN at idx = 12 -> next cycle: outputs 0, dump_active = 0, no dump_done; a later write is captured normally.
